// File: rtl/ifu_fetch.sv
// ifu_fetch: credit-limited in-order instruction fetch with redirect flush and stale-response drop
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
  logic [31:0]   pc;
  logic [CW-1:0] outstanding, drop, fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   pc_q    [FIFO_DEPTH];
  logic [31:0]   tag_q   [FIFO_DEPTH];
  logic          req_acc, rsp_ok, push, pop;
  logic          unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign imem_req_valid = rst_n && !redirect_valid && (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH);
  assign imem_req_addr  = pc;
  assign req_acc        = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && outstanding != '0;
  assign push           = rsp_ok && drop == '0 && !redirect_valid;
  assign id_valid       = fifo_count != '0 && !redirect_valid;
  assign pop            = id_valid && id_ready;
  assign id_instr       = instr_q[rd_ptr];
  assign id_pc          = pc_q[rd_ptr];
  assign id_opcode      = id_instr[6:0];
  // pc, credit counters and queue pointers; a redirect flushes and turns every in-flight request stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      outstanding <= outstanding - CW'(rsp_ok);
      drop        <= outstanding - CW'(rsp_ok);
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (req_acc) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_acc) - CW'(rsp_ok);
      if (rsp_ok && drop != '0) drop <= drop - CW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (req_acc) tag_wr <= tag_wr + AW'(1);
      if (push) tag_rd <= tag_rd + AW'(1);
    end
  end
  // request pc tags and the instruction buffer; the head tag pairs with the oldest live response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= imem_rsp_data;
        pc_q[wr_ptr]    <= tag_q[tag_rd];
      end
      if (req_acc) tag_q[tag_wr] <= pc;
    end
  end
`ifndef SYNTHESIS
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> outstanding != '0)
    else $error("ifu_fetch: response with no request outstanding");
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed fetch scenarios checked against a contiguous-PC stream model
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b1;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mq[$];
  logic [31:0] pops[$];
  logic [31:0] accs[$];
  int          cyc = 0;
  int          lat = 1;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  logic        hold = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1234_5A33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l, input logic ir);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    lat = l;
    id_ready = ir;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // memory: in-order responses a fixed number of cycles after acceptance, cleared by reset
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = f(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // model: decode sees consecutive PCs from the last reset/redirect target, requests likewise
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        exp_pc = RST_PC;
        exp_req = RST_PC;
        pops.delete();
        accs.delete();
        hold = 1'b0;
      end else begin
        if (hold && !redirect_valid) begin
          chk("hold_valid", {31'b0, id_valid}, 32'd1);
          chk("hold_pc", id_pc, hold_pc);
          chk("hold_instr", id_instr, hold_instr);
        end
        if (redirect_valid) begin
          chk("redir_id_valid", {31'b0, id_valid}, 32'd0);
          chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
          exp_pc = {redirect_pc[31:2], 2'b00};
          exp_req = {redirect_pc[31:2], 2'b00};
          pops.delete();
          accs.delete();
        end else begin
          if (id_valid && id_ready) begin
            e = f(exp_pc);
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, e);
            chk("id_opcode", {25'b0, id_opcode}, {25'b0, e[6:0]});
            pops.push_back(id_pc);
            exp_pc += 32'd4;
          end
          if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            mq.push_back('{imem_req_addr, cyc + lat});
            accs.push_back(imem_req_addr);
            exp_req += 32'd4;
          end
        end
        hold = id_valid && !id_ready && !redirect_valid;
        hold_pc = id_pc;
        hold_instr = id_instr;
      end
    end
  end

  initial begin
    logic ok;
    // 1: streaming fetch
    do_reset(1, 1'b1);
    #1;
    chk("t1_first_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_first_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("t1_addr1", imem_req_addr, 32'h8000_0004);
    chk("t1_no_bypass", {31'b0, id_valid}, 32'd0);
    chk("t1_rsp_seen", {31'b0, imem_rsp_valid}, 32'd1);
    tick();
    chk("t1_id_valid", {31'b0, id_valid}, 32'd1);
    chk("t1_id_pc0", id_pc, 32'h8000_0000);
    chk("t1_id_instr0", id_instr, 32'h9234_5A33);
    chk("t1_opcode0", {25'b0, id_opcode}, 32'h33);
    tick();
    chk("t1_id_pc1", id_pc, 32'h8000_0004);
    chk("t1_opcode1", {25'b0, id_opcode}, 32'h37);
    repeat (10) tick();
    chk("t1_acc2", accs.size() > 2 ? accs[2] : 32'hDEAD_BEEF, 32'h8000_0008);
    chk("t1_pop_rate", pops.size(), 32'd11);
    // 2: decode stalled from reset
    do_reset(1, 1'b0);
    repeat (10) tick();
    chk("t2_accepted", accs.size(), 32'd4);
    chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_head_pc", id_pc, 32'h8000_0000);
    id_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 4; i++)
      chk("t2_pop_order", pops.size() > i ? pops[i] : 32'hDEAD_BEEF, 32'h8000_0000 + 32'(4 * i));
    chk("t2_resumed", {31'b0, accs.size() > 4}, 32'd1);
    // 3: redirect with two stale requests and one buffered entry
    do_reset(3, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = mq.size() == 2 && id_valid && !imem_rsp_valid;
    end
    chk("t3_setup", {31'b0, ok}, 32'd1);
    chk("t3_buffered_pc", id_pc, 32'h8000_000C);
    chk("t3_stale0", mq.size() > 0 ? mq[0].addr : 32'hDEAD_BEEF, 32'h8000_0010);
    redirect(32'h8000_0100);
    repeat (20) tick();
    chk("t3_first_pop", pops.size() > 0 ? pops[0] : 32'hDEAD_BEEF, 32'h8000_0100);
    chk("t3_first_req", accs.size() > 0 ? accs[0] : 32'hDEAD_BEEF, 32'h8000_0100);
    // 4: redirect colliding with a live response and a pop
    do_reset(1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = imem_rsp_valid && id_valid;
    end
    chk("t4_setup", {31'b0, ok}, 32'd1);
    redirect(32'h8000_0200);
    repeat (6) tick();
    chk("t4_first_pop", pops.size() > 0 ? pops[0] : 32'hDEAD_BEEF, 32'h8000_0200);
    // 5: misaligned target and address wrap
    redirect(32'h8000_0103);
    #1;
    chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t5_aligned", imem_req_addr, 32'h8000_0100);
    repeat (6) tick();
    chk("t5_first_pop", pops.size() > 0 ? pops[0] : 32'hDEAD_BEEF, 32'h8000_0100);
    redirect(32'hFFFF_FFFC);
    repeat (8) tick();
    chk("t5_wrap_req0", accs.size() > 0 ? accs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("t5_wrap_req1", accs.size() > 1 ? accs[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    chk("t5_wrap_pop1", pops.size() > 1 ? pops[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    // 6: asynchronous reset with three requests in flight
    do_reset(3, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (mq.size() + int'(imem_rsp_valid)) == 3 && id_valid;
    end
    chk("t6_setup", {31'b0, ok}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t6_id_pc", id_pc, 32'd0);
    chk("t6_id_instr", id_instr, 32'd0);
    lat = 1;
    id_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_restart_addr", imem_req_addr, 32'h8000_0000);
    chk("t6_empty", {31'b0, id_valid}, 32'd0);
    repeat (10) tick();
    chk("t6_first_pop", pops.size() > 0 ? pops[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
